// File: rtl/ir_alu_halt_unit.sv
// ir_alu_halt_unit: instruction register with halt/hazard/branch control,
// instruction field split, and a combinational add/subtract ALU.
module ir_alu_halt_unit #(
    parameter int          DATA_W   = 16,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    input  logic [15:0]       mem_data,
    input  logic              halt,
    input  logic              hazard,
    input  logic              branch,
    output logic              ir_le,
    output logic [3:0]        opcode,
    output logic [3:0]        dest_reg,
    output logic [3:0]        src_reg1,
    output logic [3:0]        src_reg2,
    input  logic [DATA_W-1:0] in_A,
    input  logic [DATA_W-1:0] in_B,
    input  logic              add_sub,
    output logic [DATA_W-1:0] adder_out
);

    logic [15:0] ir_q;
    logic [15:0] ir_d;
    logic [3:0]  field [4];

    // Halt gate: a halted instruction stops further fetch into the IR.
    always_comb begin
        ir_le = ~halt;
    end

    // Next IR value: flush beats stall, stall beats halt, otherwise load.
    always_comb begin
        ir_d = ir_q;
        if (branch) begin
            ir_d = NOP_WORD;
        end else if (hazard) begin
            ir_d = ir_q;
        end else if (!ir_le) begin
            ir_d = ir_q;
        end else begin
            ir_d = mem_data;
        end
    end

    // IR state register; reset loads the NOP word without waiting for clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q <= NOP_WORD;
        end else begin
            ir_q <= ir_d;
        end
    end

    // Split the IR into four nibble fields, most significant first. Fields
    // are forced to zero while reset is asserted so they read 0 even if
    // NOP_WORD is overridden with a non-zero value.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_field
            assign field[gi] = rst ? ir_q[15 - 4*gi -: 4] : 4'h0;
        end
    endgenerate

    assign opcode   = field[0];
    assign dest_reg = field[1];
    assign src_reg1 = field[2];
    assign src_reg2 = field[3];

    // ALU: add or subtract with silent two's-complement wrap.
    always_comb begin
        if (add_sub) begin
            adder_out = in_A - in_B;
        end else begin
            adder_out = in_A + in_B;
        end
    end

endmodule

// File: tb/tb_ir_alu_halt_unit.sv
// Directed, table-driven testbench for ir_alu_halt_unit.
module tb_ir_alu_halt_unit;

    logic        clk;
    logic        rst;
    logic [15:0] mem_data;
    logic        halt;
    logic        hazard;
    logic        branch;
    logic        ir_le;
    logic [3:0]  opcode;
    logic [3:0]  dest_reg;
    logic [3:0]  src_reg1;
    logic [3:0]  src_reg2;
    logic [15:0] in_A;
    logic [15:0] in_B;
    logic        add_sub;
    logic [15:0] adder_out;

    int checks = 0;
    int errors = 0;

    ir_alu_halt_unit #(.DATA_W(16), .NOP_WORD(16'h0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_data (mem_data),
        .halt     (halt),
        .hazard   (hazard),
        .branch   (branch),
        .ir_le    (ir_le),
        .opcode   (opcode),
        .dest_reg (dest_reg),
        .src_reg1 (src_reg1),
        .src_reg2 (src_reg2),
        .in_A     (in_A),
        .in_B     (in_B),
        .add_sub  (add_sub),
        .adder_out(adder_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mem;
        logic        hlt;
        logic        haz;
        logic        br;
        logic [15:0] exp_ir;
    } ir_vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] exp_out;
    } alu_vec_t;

    ir_vec_t  ir_tab  [13];
    alu_vec_t alu_tab [6];

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic check_fields(input string name, input logic [15:0] exp);
        check16(name, {opcode, dest_reg, src_reg1, src_reg2}, exp);
    endtask

    initial begin
        // IR sequence: each row is applied, one rising edge, then checked.
        ir_tab[0]  = '{16'hA5C3, 0, 0, 0, 16'hA5C3};
        ir_tab[1]  = '{16'hFFFF, 0, 1, 0, 16'hA5C3};  // hazard holds
        ir_tab[2]  = '{16'hFFFF, 0, 1, 0, 16'hA5C3};
        ir_tab[3]  = '{16'hFFFF, 0, 0, 0, 16'hFFFF};  // hazard drops
        ir_tab[4]  = '{16'h7123, 0, 0, 0, 16'h7123};
        ir_tab[5]  = '{16'h9999, 0, 1, 1, 16'h0000};  // branch beats hazard
        ir_tab[6]  = '{16'h2456, 0, 0, 0, 16'h2456};
        ir_tab[7]  = '{16'h3333, 1, 0, 0, 16'h2456};  // halt holds
        ir_tab[8]  = '{16'h4444, 1, 0, 0, 16'h2456};
        ir_tab[9]  = '{16'h5555, 1, 0, 0, 16'h2456};
        ir_tab[10] = '{16'h6666, 1, 0, 1, 16'h0000};  // branch beats halt
        ir_tab[11] = '{16'h6666, 0, 0, 0, 16'h6666};  // halt released
        ir_tab[12] = '{16'h1111, 1, 1, 0, 16'h6666};  // hazard + halt hold

        alu_tab[0] = '{16'h0005, 16'h0003, 0, 16'h0008};
        alu_tab[1] = '{16'hFFFF, 16'h0001, 0, 16'h0000};
        alu_tab[2] = '{16'h0003, 16'h0005, 1, 16'hFFFE};
        alu_tab[3] = '{16'h8000, 16'h0001, 1, 16'h7FFF};
        alu_tab[4] = '{16'h1234, 16'h1111, 1, 16'h0123};
        alu_tab[5] = '{16'h7FFF, 16'h0001, 0, 16'h8000};

        rst = 1'b0; mem_data = 16'h1234; halt = 0; hazard = 0; branch = 0;
        in_A = 0; in_B = 0; add_sub = 0;

        // Reset held: fields stay zero across edges.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_fields($sformatf("reset_hold_%0d", i), 16'h0000);
        end
        @(negedge clk); rst = 1'b1;
        #1 check_fields("after_release_no_edge", 16'h0000);
        @(posedge clk); #1;
        check_fields("first_load", 16'h1234);

        // Table-driven IR control sequence.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            mem_data = ir_tab[i].mem;
            halt     = ir_tab[i].hlt;
            hazard   = ir_tab[i].haz;
            branch   = ir_tab[i].br;
            #1 check16($sformatf("ir_le_%0d", i), {15'h0, ir_le}, {15'h0, ~ir_tab[i].hlt});
            @(posedge clk); #1;
            check_fields($sformatf("ir_vec_%0d", i), ir_tab[i].exp_ir);
        end

        // Asynchronous reset mid-cycle, then release with a branch pending.
        @(negedge clk);
        halt = 0; hazard = 0; branch = 0; mem_data = 16'hBEEF;
        @(posedge clk); #1 check_fields("pre_async", 16'hBEEF);
        #2 rst = 1'b0;
        #1 check_fields("async_reset", 16'h0000);
        @(negedge clk); rst = 1'b1; branch = 1;
        @(posedge clk); #1 check_fields("release_branch", 16'h0000);
        @(negedge clk); branch = 0; mem_data = 16'hC0DE;
        @(posedge clk); #1 check_fields("release_load", 16'hC0DE);

        // ALU: combinational, checked between clock edges.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_A    = alu_tab[i].a;
            in_B    = alu_tab[i].b;
            add_sub = alu_tab[i].sub;
            #1 check16($sformatf("alu_%0d", i), adder_out, alu_tab[i].exp_out);
        end

        // ALU responds while reset is asserted.
        rst = 1'b0; in_A = 16'h0010; in_B = 16'h0020; add_sub = 0;
        #1 check16("alu_in_reset", adder_out, 16'h0030);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
